// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with two combinational read
// ports, two write-back ports (E from the ALU stage, M from the memory stage),
// same-cycle write-to-read bypass and a per-register busy scoreboard that
// drives the decode stall. Index NONE is a hard-wired zero register; writes
// and issues addressed to it are dropped.
module regfile_sb #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4,
    parameter int NONE   = NREGS - 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         srcA,
    input  logic [ADDR_W-1:0]         srcB,
    output logic [DATA_W-1:0]         valA,
    output logic [DATA_W-1:0]         valB,
    input  logic [ADDR_W-1:0]         dstE,
    input  logic [DATA_W-1:0]         valE,
    input  logic [ADDR_W-1:0]         dstM,
    input  logic [DATA_W-1:0]         valM,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_dst,
    output logic                      stall,
    output logic [NREGS-1:0]          busy,
    output logic [NREGS*DATA_W-1:0]   REGS
);

    localparam logic [ADDR_W-1:0] NONE_IDX = ADDR_W'(NONE);

    // Architectural state
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    // Decoded write/issue qualifiers
    logic we_e_s;
    logic we_m_s;
    logic iss_s;

    // Stored values at the read indices (before bypass)
    logic [DATA_W-1:0] stored_a_s;
    logic [DATA_W-1:0] stored_b_s;
    logic              pend_a_s;
    logic              pend_b_s;

    // Bypassed read: M is the newer producer, so it is checked before E.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] s,
        input logic [DATA_W-1:0] stored,
        input logic [ADDR_W-1:0] dst_e,
        input logic [DATA_W-1:0] val_e,
        input logic [ADDR_W-1:0] dst_m,
        input logic [DATA_W-1:0] val_m
    );
        logic [DATA_W-1:0] r;
        if (s == NONE_IDX) begin
            r = {DATA_W{1'b0}};
        end else if (s == dst_m) begin
            r = val_m;
        end else if (s == dst_e) begin
            r = val_e;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // A source is pending when its producer is outstanding and no write-back
    // this cycle can forward it.
    function automatic logic pend_sel(
        input logic [ADDR_W-1:0] s,
        input logic              busy_bit,
        input logic [ADDR_W-1:0] dst_e,
        input logic [ADDR_W-1:0] dst_m
    );
        logic p;
        if (s == NONE_IDX) begin
            p = 1'b0;
        end else if ((s == dst_e) || (s == dst_m)) begin
            p = 1'b0;
        end else begin
            p = busy_bit;
        end
        return p;
    endfunction

    // Qualify the write and issue ports against the NONE index
    always_comb begin
        we_e_s = (dstE != NONE_IDX);
        we_m_s = (dstM != NONE_IDX);
        iss_s  = issue_valid && (issue_dst != NONE_IDX);
    end

    // Combinational read ports with bypass and stall generation
    always_comb begin
        stored_a_s = regs_q[srcA];
        stored_b_s = regs_q[srcB];
        valA       = read_sel(srcA, stored_a_s, dstE, valE, dstM, valM);
        valB       = read_sel(srcB, stored_b_s, dstE, valE, dstM, valM);
        pend_a_s   = pend_sel(srcA, busy_q[srcA], dstE, dstM);
        pend_b_s   = pend_sel(srcB, busy_q[srcB], dstE, dstM);
        stall      = pend_a_s | pend_b_s;
    end

    // Next register contents: E first, then M so M wins a collision
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_d[i] = {DATA_W{1'b0}};
            end
        end else begin
            if (we_e_s) begin
                regs_d[dstE] = valE;
            end else begin
                regs_d[dstE] = regs_q[dstE];
            end
            if (we_m_s) begin
                regs_d[dstM] = valM;
            end else begin
                regs_d[dstM] = regs_d[dstM];
            end
        end
        regs_d[NONE_IDX] = {DATA_W{1'b0}};
    end

    // Next scoreboard: writes clear, then an issue sets (set wins)
    always_comb begin
        busy_d = busy_q;
        if (reset) begin
            busy_d = {NREGS{1'b0}};
        end else begin
            if (we_e_s) begin
                busy_d[dstE] = 1'b0;
            end else begin
                busy_d[dstE] = busy_d[dstE];
            end
            if (we_m_s) begin
                busy_d[dstM] = 1'b0;
            end else begin
                busy_d[dstM] = busy_d[dstM];
            end
            if (iss_s) begin
                busy_d[issue_dst] = 1'b1;
            end else begin
                busy_d[issue_dst] = busy_d[issue_dst];
            end
        end
        busy_d[NONE_IDX] = 1'b0;
    end

    // State registers; reset is folded into the next-state logic above
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
        busy_q <= busy_d;
    end

    // Export the register array and scoreboard straight from the flops
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            REGS[i*DATA_W +: DATA_W] = regs_q[i];
        end
        busy = busy_q;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by a
// randomized run, all checked against an array-based reference model.
module tb_regfile_sb;

    localparam int DW   = 16;
    localparam int NR   = 16;
    localparam int AW   = 4;
    localparam logic [AW-1:0] NONE = 4'd15;

    logic            clk;
    logic            reset;
    logic [AW-1:0]   srcA, srcB, dstE, dstM, issue_dst;
    logic [DW-1:0]   valE, valM;
    logic            issue_valid;
    logic [DW-1:0]   valA, valB;
    logic            stall;
    logic [NR-1:0]   busy;
    logic [NR*DW-1:0] REGS;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_busy;

    regfile_sb #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .issue_valid(issue_valid), .issue_dst(issue_dst),
        .stall(stall), .busy(busy), .REGS(REGS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] s);
        if (s == NONE) return 16'h0000;
        if (s == dstM) return valM;
        if (s == dstE) return valE;
        return m_regs[s];
    endfunction

    function automatic logic exp_pend(input logic [AW-1:0] s);
        return m_busy[s] && (s != NONE) && (s != dstE) && (s != dstM);
    endfunction

    function automatic logic [NR*DW-1:0] exp_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
        return f;
    endfunction

    task automatic idle();
        dstE = NONE; dstM = NONE; valE = 16'h0000; valM = 16'h0000;
        issue_valid = 1'b0; issue_dst = NONE;
    endtask

    // advance one clock; the model consumes the inputs the DUT samples
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < NR; i++) m_regs[i] = 16'h0000;
            m_busy = 16'h0000;
        end else begin
            if (dstE != NONE) begin m_regs[dstE] = valE; m_busy[dstE] = 1'b0; end
            if (dstM != NONE) begin m_regs[dstM] = valM; m_busy[dstM] = 1'b0; end
            if (issue_valid && issue_dst != NONE) m_busy[issue_dst] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; srcA = 4'd0; srcB = 4'd14;
        dstE = 4'd3; valE = 16'hAAAA; dstM = 4'd4; valM = 16'h5555;
        issue_valid = 1'b1; issue_dst = 4'd6;
        tick();
        tick();
        reset = 1'b0; idle();
        #1;
        checks++; if (valA !== 16'h0000) begin errors++; $display("FAIL reset_valA got %h exp 0000", valA); end
        checks++; if (valB !== 16'h0000) begin errors++; $display("FAIL reset_valB got %h exp 0000", valB); end
        checks++; if (busy !== 16'h0000) begin errors++; $display("FAIL reset_busy got %h exp 0000", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (REGS !== '0) begin errors++; $display("FAIL reset_regs got %h exp 0", REGS); end
    endtask

    task automatic test_write_read();
        dstE = 4'd3; valE = 16'h1234;
        tick();
        idle(); srcA = 4'd3;
        #1;
        checks++; if (valA !== 16'h1234) begin errors++; $display("FAIL wr_valA got %h exp 1234", valA); end
        checks++; if (REGS[63:48] !== 16'h1234) begin errors++; $display("FAIL wr_regs3 got %h exp 1234", REGS[63:48]); end
    endtask

    task automatic test_bypass();
        dstM = 4'd5; valM = 16'hBEEF; srcB = 4'd5;
        #1;
        checks++; if (valB !== 16'hBEEF) begin errors++; $display("FAIL bypass_valB got %h exp beef", valB); end
        tick();
        idle();
    endtask

    task automatic test_collision();
        dstE = 4'd7; valE = 16'h0001; dstM = 4'd7; valM = 16'h0002; srcA = 4'd7;
        #1;
        checks++; if (valA !== 16'h0002) begin errors++; $display("FAIL coll_read got %h exp 0002", valA); end
        tick();
        idle();
        #1;
        checks++; if (REGS[7*DW +: DW] !== 16'h0002) begin errors++; $display("FAIL coll_reg7 got %h exp 0002", REGS[7*DW +: DW]); end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_dst = 4'd2; srcA = 4'd0; srcB = 4'd0;
        tick();
        idle(); srcA = 4'd2;
        #1;
        checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL sb_busy2_set got %b exp 1", busy[2]); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall got %b exp 1", stall); end
        dstM = 4'd2; valM = 16'h0009;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_stall_fwd got %b exp 0", stall); end
        checks++; if (valA !== 16'h0009) begin errors++; $display("FAIL sb_valA got %h exp 0009", valA); end
        tick();
        idle();
        #1;
        checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL sb_busy2_clr got %b exp 0", busy[2]); end
    endtask

    task automatic test_none_setwins();
        dstE = NONE; valE = 16'hFFFF;
        tick();
        idle(); srcA = NONE;
        #1;
        checks++; if (valA !== 16'h0000) begin errors++; $display("FAIL none_read got %h exp 0000", valA); end
        checks++; if (REGS[255:240] !== 16'h0000) begin errors++; $display("FAIL none_reg got %h exp 0000", REGS[255:240]); end
        issue_valid = 1'b1; issue_dst = 4'd4; dstE = 4'd4; valE = 16'h4444;
        tick();
        idle();
        #1;
        checks++; if (busy[4] !== 1'b1) begin errors++; $display("FAIL setwins_busy4 got %b exp 1", busy[4]); end
        reset = 1'b1; dstE = 4'd8; valE = 16'h8888;
        tick();
        reset = 1'b0; idle();
        #1;
        checks++; if (busy !== 16'h0000) begin errors++; $display("FAIL rst_busy got %h exp 0000", busy); end
        checks++; if (REGS[8*DW +: DW] !== 16'h0000) begin errors++; $display("FAIL rst_drop_write got %h exp 0000", REGS[8*DW +: DW]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            srcA = AW'($urandom_range(0, 15));
            srcB = AW'($urandom_range(0, 15));
            dstE = ($urandom_range(0, 2) == 0) ? NONE : AW'($urandom_range(0, 15));
            dstM = ($urandom_range(0, 2) == 0) ? NONE : AW'($urandom_range(0, 15));
            valE = DW'($urandom);
            valM = DW'($urandom);
            issue_dst = AW'($urandom_range(0, 15));
            issue_valid = ($urandom_range(0, 1) == 1);
            // decode never issues while stalled
            if (exp_pend(srcA) || exp_pend(srcB)) issue_valid = 1'b0;
            #1;
            checks++; if (valA !== exp_read(srcA)) begin errors++; $display("FAIL rnd_valA n=%0d got %h exp %h", n, valA, exp_read(srcA)); end
            checks++; if (valB !== exp_read(srcB)) begin errors++; $display("FAIL rnd_valB n=%0d got %h exp %h", n, valB, exp_read(srcB)); end
            checks++; if (stall !== (exp_pend(srcA) || exp_pend(srcB))) begin errors++; $display("FAIL rnd_stall n=%0d got %b exp %b", n, stall, exp_pend(srcA) || exp_pend(srcB)); end
            tick();
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy n=%0d got %h exp %h", n, busy, m_busy); end
            checks++; if (REGS !== exp_flat()) begin errors++; $display("FAIL rnd_regs n=%0d got %h exp %h", n, REGS, exp_flat()); end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) m_regs[i] = 16'h0000;
        m_busy = 16'h0000;
        reset = 1'b1; srcA = 4'd0; srcB = 4'd0;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_collision();
        test_scoreboard();
        test_none_setwins();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the SimpleCPU datapath: two combinational read ports (A, B), two write-back ports (E from the ALU stage, M from the memory stage), and a per-register busy scoreboard. It adds synchronous clearing, a fixed write-port priority, same-cycle write-to-read bypass, and a stall output for reads of registers with an outstanding producer. It sits between decode (reads, issue) and write-back (E/M writes), and exports the full register array for debug display.

## Interface
- DATA_W, 16, register width in bits
- NREGS, 16, number of architectural registers; must be a power of two, at least 4
- ADDR_W, 4, register index width; must equal log2(NREGS)
- NONE, NREGS-1, "no register" index: reads return 0, writes and issues to it are ignored

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- srcA  in  ADDR_W  read port A index
- srcB  in  ADDR_W  read port B index
- valA  out  DATA_W  read data A (combinational)
- valB  out  DATA_W  read data B (combinational)
- dstE  in  ADDR_W  write port E index; NONE means no write
- valE  in  DATA_W  write port E data
- dstM  in  ADDR_W  write port M index; NONE means no write
- valM  in  DATA_W  write port M data
- issue_valid  in  1  decode issues an instruction that will write issue_dst
- issue_dst  in  ADDR_W  destination being reserved
- stall  out  1  a source read depends on a pending, not-yet-written register
- busy  out  NREGS  scoreboard bits; bit NONE is always 0
- REGS  out  NREGS*DATA_W  flat register array; register i occupies bits [i*DATA_W +: DATA_W]

## Operation
- Storage: NREGS x DATA_W. Entry NONE is constant 0 and is never written.
- Write: on each edge, if dstE != NONE then reg[dstE] <= valE. If dstM != NONE then reg[dstM] <= valM.
- Write collision: if dstE == dstM != NONE, M wins (the later pipeline stage holds the newer value).
- Read with bypass, evaluated per port for index s:
  - s == NONE → 0
  - else if s == dstM → valM
  - else if s == dstE → valE
  - else → reg[s]
- Scoreboard, updated per edge:
  - A write on E or M to register r clears busy[r].
  - issue_valid with issue_dst != NONE sets busy[issue_dst].
  - If the same register is both written and issued in one cycle, the set wins.
- Stall:
  - stall = (pendA | pendB).
  - pendX = busy[srcX] and srcX != NONE and srcX is not being written this cycle on E or M (the bypass covers it).
- The block never gates its own issue on stall; decode must not assert issue_valid while stall is high.
- Reset: all registers, including NONE, are 0. All busy bits are 0. Write and issue inputs are ignored in the reset cycle.

## Timing
- Read latency 0: valA, valB and stall are combinational from the src, dst, val and busy inputs.
- Write latency 1: a value appears in REGS and in non-bypassed reads after the edge that captures it.
- busy changes one edge after the issue or write that causes it.
- Reset values: REGS = 0, busy = 0. While reset is high and src inputs are stable, stall = 0 and valA = valB = 0, except when a read bypasses a same-cycle write.
- Reset asserted while registers are busy: all busy bits and data clear at that edge. Writes arriving in that cycle are dropped.
- Wrap/width: indices are ADDR_W bits with no out-of-range values. Data is stored unmodified, with no sign extension.

## Test plan
- Reset then read: assert reset for 1 cycle, then read srcA=0, srcB=14 → valA=0, valB=0, busy=0, stall=0.
- Write then read: cycle 1 dstE=3, valE=16'h1234; cycle 2 srcA=3 → valA=16'h1234, REGS[63:48]=16'h1234.
- Bypass: in one cycle, dstM=5, valM=16'hBEEF and srcB=5 → valB=16'hBEEF in that same cycle.
- E/M collision: dstE=dstM=7, valE=16'h0001, valM=16'h0002 → same-cycle read of 7 gives 16'h0002; after the edge reg[7]=16'h0002.
- Scoreboard stall:
  - issue_valid=1, issue_dst=2 → next cycle busy[2]=1, and srcA=2 gives stall=1.
  - Next, dstM=2, valM=9 in the same cycle → stall=0, valA=9.
  - After the edge, busy[2]=0.
- NONE and set-wins:
  - dstE=15, valE=16'hFFFF → reg[15] stays 0 and a read of 15 gives 0.
  - issue_dst=4 together with dstE=4 in one cycle → busy[4]=1 afterwards.
  - Reset asserted with busy[4]=1 → busy=0 after the edge.
